// File: rtl/cfs_cdc_tx_ctrl.sv
// Source side of a 4-phase req/ack CDC handshake: latches a word, raises cdc_req and tracks the synchronized ack.
// Optional wait-state timeout abort is compiled in with macro CFS_CDC_TIMEOUT_EN.
module cfs_cdc_tx_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ready,
  output logic                  cdc_req,
  output logic [DATA_WIDTH-1:0] cdc_data,
  input  logic                  cdc_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("cfs_cdc_tx_ctrl: SYNC_STAGES must be at least 2");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
    $error("cfs_cdc_tx_ctrl: TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [SYNC_STAGES-1:0] ack_sync_r;
  logic                   ack_s;
  logic                   accept_s;
  logic                   req_next_s;
  logic                   done_next_s;
  logic                   err_next_s;
  logic                   load_s;

`ifdef CFS_CDC_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] to_cnt_r;
  logic        to_hit_s;
  logic        abort_r;
  logic        abort_next_s;

  assign to_hit_s = (to_cnt_r == TO_LAST);

  // Wait-state cycle counter: restarts on every state change, counts while in REQ/REL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_r <= 16'd0;
    end else if (state_next_s != state_r) begin
      to_cnt_r <= 16'd0;
    end else if (state_r != IDLE) begin
      to_cnt_r <= to_cnt_r + 16'd1;
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Remembers that REL was entered by a REQ timeout, so its exit must not report done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      abort_r <= 1'b0;
    end else begin
      abort_r <= abort_next_s;
    end
  end
`endif

  // Ack synchronizer; only the last stage feeds the control logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_sync_r <= '0;
    end else begin
      ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], cdc_ack};
    end
  end

  assign ack_s = ack_sync_r[SYNC_STAGES-1];

  // A lingering ack from the previous handshake must be seen low before a new word goes out.
  assign push_ready = (state_r == IDLE) && !ack_s && !reset;
  assign accept_s   = push_valid && push_ready;

  // Next-state and registered-output decode.
  always_comb begin
    state_next_s = state_r;
    req_next_s   = cdc_req;
    done_next_s  = 1'b0;
    err_next_s   = 1'b0;
    load_s       = 1'b0;
`ifdef CFS_CDC_TIMEOUT_EN
    abort_next_s = abort_r;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = REQ;
          req_next_s   = 1'b1;
          load_s       = 1'b1;
`ifdef CFS_CDC_TIMEOUT_EN
          abort_next_s = 1'b0;
`endif
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (ack_s) begin
          state_next_s = REL;
          req_next_s   = 1'b0;
`ifdef CFS_CDC_TIMEOUT_EN
          abort_next_s = 1'b0;
        end else if (to_hit_s) begin
          state_next_s = REL;
          req_next_s   = 1'b0;
          err_next_s   = 1'b1;
          abort_next_s = 1'b1;
`endif
        end else begin
          state_next_s = REQ;
        end
      end
      REL: begin
        if (!ack_s) begin
          state_next_s = IDLE;
`ifdef CFS_CDC_TIMEOUT_EN
          done_next_s  = !abort_r;
          abort_next_s = 1'b0;
        end else if (to_hit_s) begin
          state_next_s = IDLE;
          err_next_s   = 1'b1;
          abort_next_s = 1'b0;
`else
          done_next_s  = 1'b1;
`endif
        end else begin
          state_next_s = REL;
        end
      end
      default: begin
        state_next_s = IDLE;
        req_next_s   = 1'b0;
      end
    endcase
  end

  // State register and handshake outputs; reset drops cdc_req immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cdc_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cdc_req <= req_next_s;
      busy    <= (state_next_s != IDLE);
      done    <= done_next_s;
      err     <= err_next_s;
    end
  end

  // Data word is held from one accepted push to the next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdc_data <= '0;
    end else if (load_s) begin
      cdc_data <= push_data;
    end else begin
      cdc_data <= cdc_data;
    end
  end

endmodule

// File: tb/tb_cfs_cdc_tx_ctrl.sv
// Directed self-checking bench for cfs_cdc_tx_ctrl (SYNC_STAGES=2); adds a timeout test when CFS_CDC_TIMEOUT_EN is defined.
module tb_cfs_cdc_tx_ctrl;
`ifdef CFS_CDC_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        push_valid;
  logic [31:0] push_data;
  logic        push_ready;
  logic        cdc_req;
  logic [31:0] cdc_data;
  logic        cdc_ack;
  logic        busy;
  logic        done;
  logic        err;
  logic        ack_follow;
  logic        ack_force;

  int n_pass   = 0;
  int n_total  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  // Destination model: either echoes cdc_req directly or holds a forced level.
  assign cdc_ack = ack_follow ? cdc_req : ack_force;

  cfs_cdc_tx_ctrl #(
    .DATA_WIDTH (32),
    .SYNC_STAGES(2),
    .TIMEOUT    (TO_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .push_valid(push_valid),
    .push_data (push_data),
    .push_ready(push_ready),
    .cdc_req   (cdc_req),
    .cdc_data  (cdc_data),
    .cdc_ack   (cdc_ack),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled on the rising edge so negedge reads never race them.
  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One transfer with ack echoing req; accept cycle is 0, done expected in cycle 7.
  task automatic do_xfer(input logic [31:0] d);
    int d0;
    d0 = done_cnt;
    push_valid = 1'b1;
    push_data  = d;
    ack_follow = 1'b1;
    #1 check("xfer_ready", 32'(push_ready), 32'd1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        push_valid = 1'b0;
        push_data  = ~d;
      end
      check("xfer_req", 32'(cdc_req), (c <= 3) ? 32'd1 : 32'd0);
      check("xfer_done", 32'(done), (c == 7) ? 32'd1 : 32'd0);
      check("xfer_data", cdc_data, d);
    end
    check("xfer_done_cnt", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    int e0;
    int seen;

    // Reset with ack high and a push pending.
    reset      = 1'b1;
    push_valid = 1'b1;
    push_data  = 32'hDEAD_BEEF;
    ack_follow = 1'b0;
    ack_force  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(cdc_req), 32'd0);
    check("rst_data", cdc_data, 32'd0);
    check("rst_ready", 32'(push_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    reset      = 1'b0;
    push_valid = 1'b0;
    ack_force  = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_ready", 32'(push_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Single transfer.
    do_xfer(32'hA5A5_0001);

    // Back-to-back: valid held, second word only goes out once the first completes.
    push_valid = 1'b1;
    push_data  = 32'h0000_0001;
    #1 check("b2b_ready0", 32'(push_ready), 32'd1);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) push_data = 32'h0000_0002;
      check("b2b_data1", cdc_data, 32'h0000_0001);
      check("b2b_ready", 32'(push_ready), (c == 7) ? 32'd1 : 32'd0);
      check("b2b_done1", 32'(done), (c == 7) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    push_valid = 1'b0;
    check("b2b_data2", cdc_data, 32'h0000_0002);
    check("b2b_req2", 32'(cdc_req), 32'd1);
    repeat (6) @(negedge clk);
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_data2_hold", cdc_data, 32'h0000_0002);
    @(negedge clk);

    // Stuck-high ack in IDLE blocks acceptance until two cycles after it falls.
    ack_follow = 1'b0;
    ack_force  = 1'b1;
    repeat (2) @(negedge clk);
    push_valid = 1'b1;
    push_data  = 32'h0000_0033;
    for (int c = 0; c < 8; c++) begin
      check("stuck_ready", 32'(push_ready), 32'd0);
      check("stuck_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    ack_force = 1'b0;
    check("stuck_fall0", 32'(push_ready), 32'd0);
    @(negedge clk);
    check("stuck_fall1", 32'(push_ready), 32'd0);
    @(negedge clk);
    check("stuck_fall2", 32'(push_ready), 32'd1);
    @(negedge clk);
    push_valid = 1'b0;
    check("stuck_req", 32'(cdc_req), 32'd1);
    check("stuck_data", cdc_data, 32'h0000_0033);
    ack_follow = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check("stuck_done_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);

    // Reset while in REQ drops cdc_req without waiting for a clock.
    d0 = done_cnt;
    e0 = err_cnt;
    push_valid = 1'b1;
    push_data  = 32'h0000_0044;
    @(negedge clk);
    push_valid = 1'b0;
    @(negedge clk);
    check("mid_req_high", 32'(cdc_req), 32'd1);
    reset = 1'b1;
    #1 check("mid_req_async", 32'(cdc_req), 32'd0);
    check("mid_req_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while in REL: immediate IDLE, no pulses, then a normal transfer.
    push_valid = 1'b1;
    push_data  = 32'h0000_0066;
    @(negedge clk);
    push_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rel_busy", 32'(busy), 32'd1);
    check("rel_req", 32'(cdc_req), 32'd0);
    reset = 1'b1;
    #1 check("rel_rst_busy", 32'(busy), 32'd0);
    check("rel_rst_ready", 32'(push_ready), 32'd0);
    check("rel_rst_data", cdc_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("mid_rst_no_err", 32'(err_cnt - e0), 32'd0);
    do_xfer(32'h7777_0007);

`ifdef CFS_CDC_TIMEOUT_EN
    // Ack never arrives: err in cycle 9 (8 after REQ entry), IDLE one cycle later, no done.
    d0 = done_cnt;
    ack_follow = 1'b0;
    ack_force  = 1'b0;
    push_valid = 1'b1;
    push_data  = 32'h0000_0055;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) push_valid = 1'b0;
      check("to_err", 32'(err), (c == 9) ? 32'd1 : 32'd0);
      check("to_req", 32'(cdc_req), (c <= 8) ? 32'd1 : 32'd0);
      check("to_busy", 32'(busy), (c <= 9) ? 32'd1 : 32'd0);
    end
    check("to_no_done", 32'(done_cnt - d0), 32'd0);
    check("to_err_cnt", 32'(err_cnt), 32'd1);
`else
    check("no_err_ever", 32'(err_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
